// File: rtl/pulse_level_gen.sv
// pulse_level_gen
//
// Turns single-cycle strobes into clean fixed-width levels: each accepted strobe
// produces HIGH_CYCLES cycles of pulse_out=1 followed by GAP_CYCLES cycles of
// pulse_out=0. Downstream edge detectors therefore see exactly one rising edge
// per strobe. Strobes arriving while a level is in progress are queued in a
// saturating pending counter and replayed back to back.
//
// Build option:
//   PULSE_QUEUE_EN  defined   -> strobes during HIGH/GAP are queued (up to 2^PEND_W-1)
//                   undefined -> no queue; such strobes are dropped, except a strobe
//                                on the final GAP cycle, which starts the next level
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   strobe     one request per high cycle
//   pulse_out  generated level (registered)
//   busy       high whenever the FSM is not idle (registered)
//   pending    queued requests not yet started (0 when the queue is not built)
//   overflow   one-cycle registered pulse per dropped request
module pulse_level_gen #(
   parameter int unsigned HIGH_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 16,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned PEND_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              strobe,
   output logic              pulse_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

   localparam logic [CNT_W-1:0] HighLoad = CNT_W'(HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GapLoad  = CNT_W'(GAP_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
   logic             busy_q, busy_d;
   logic             ovf_q;

   logic gap_end;   // last GAP cycle: the level/idle decision is made here
   logic pend_nz;
   logic consumed;  // strobe starts a level directly this cycle
   logic drop;

   assign gap_end  = (state_q == StGap) && (cnt_q == '0);
   assign consumed = strobe && ((state_q == StIdle) || (gap_end && !pend_nz));

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (strobe) begin
               state_d = StHigh;
               cnt_d   = HighLoad;
            end
         end
         StHigh: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = StGap;
               cnt_d   = GapLoad;
            end
         end
         StGap: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (pend_nz || strobe) begin
               state_d = StHigh;
               cnt_d   = HighLoad;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic, computed from the next state so the registered outputs
   // line up with the state register.
   always_comb begin
      pulse_d = (state_d == StHigh);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
         ovf_q   <= drop;
      end
   end

`ifdef PULSE_QUEUE_EN
   localparam logic [PEND_W-1:0] PendMax = {PEND_W{1'b1}};

   logic [PEND_W-1:0] pend_q, pend_d;
   logic              enq;
   logic              deq;

   always_comb begin
      enq    = strobe && !consumed;
      deq    = gap_end && pend_nz;
      pend_d = pend_q;
      drop   = 1'b0;
      // Simultaneous enqueue and dequeue leaves the count unchanged, so a
      // full counter only drops when nothing leaves it this cycle.
      if (enq && !deq) begin
         if (pend_q == PendMax) begin
            drop = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end else if (deq && !enq) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend_nz = (pend_q != '0);
   assign pending = pend_q;
`else
   assign pend_nz = 1'b0;
   assign pending = '0;

   always_comb begin
      drop = strobe && !consumed;
   end
`endif

   assign pulse_out = pulse_q;
   assign busy      = busy_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_level_gen.sv
// Scoreboard bench for pulse_level_gen (HIGH=4, GAP=2, PEND_W=2).
// Stimulus pushes expected levels, overflow cycles and sampled signal values
// into queues; a monitor compares them against the DUT on every falling edge.
// Cycle n means the clock period that follows rising edge n.
module tb_pulse_level_gen;

   localparam int unsigned HIGH   = 4;
   localparam int unsigned GAP    = 2;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned PEND_W = 2;

   localparam int SigPulse = 0;
   localparam int SigBusy  = 1;
   localparam int SigPend  = 2;
   localparam int SigOvf   = 3;

   logic              clk    = 1'b0;
   logic              rst    = 1'b0;
   logic              strobe = 1'b0;
   logic              pulse_out;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              overflow;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {int cyc; int sig; int val;} probe_t;
   typedef struct {int start; int width;} level_t;

   probe_t probe_q[$];
   level_t level_q[$];
   int     ovf_q[$];

   pulse_level_gen #(
      .HIGH_CYCLES (HIGH),
      .GAP_CYCLES  (GAP),
      .CNT_W       (CNT_W),
      .PEND_W      (PEND_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .strobe    (strobe),
      .pulse_out (pulse_out),
      .busy      (busy),
      .pending   (pending),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic exp_probe(input int c, input int s, input int v);
      probe_t p;
      int     i;
      p.cyc = c;
      p.sig = s;
      p.val = v;
      i = 0;
      while (i < probe_q.size() && probe_q[i].cyc <= c) i++;
      probe_q.insert(i, p);
   endtask

   task automatic exp_level(input int st, input int w);
      level_t l;
      l.start = st;
      l.width = w;
      level_q.push_back(l);
   endtask

   task automatic exp_ovf(input int c);
      int i;
      i = 0;
      while (i < ovf_q.size() && ovf_q[i] <= c) i++;
      ovf_q.insert(i, c);
   endtask

   // Drive inputs so they are sampled at rising edge e.
   task automatic set_at(input int e, input logic s, input logic r);
      while (cyc < e - 1) @(negedge clk);
      if (cyc != e - 1) begin
         $display("FAIL schedule: edge %0d already passed (cyc %0d)", e, cyc);
         $fatal(1);
      end
      strobe = s;
      rst    = r;
   endtask

   task automatic pulse(input int e);
      set_at(e, 1'b1, 1'b1);
      set_at(e + 1, 1'b0, 1'b1);
   endtask

   function automatic logic [31:0] sig_val(input int s);
      case (s)
         SigPulse: return {31'b0, pulse_out};
         SigBusy:  return {31'b0, busy};
         SigPend:  return 32'(pending);
         default:  return {31'b0, overflow};
      endcase
   endfunction

   // Monitor
   initial begin
      probe_t      p;
      level_t      l;
      int          start;
      logic        prev;
      logic [31:0] got;
      start = 0;
      prev  = 1'b0;
      forever begin
         @(negedge clk);
         while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            checks++;
            got = sig_val(p.sig);
            if (p.cyc < cyc) begin
               errors++;
               $display("FAIL probe sig%0d cyc %0d: not sampled (now %0d)", p.sig, p.cyc, cyc);
            end else if (got !== 32'(p.val)) begin
               errors++;
               $display("FAIL probe sig%0d cyc %0d: got %0h want %0h", p.sig, p.cyc, got, p.val);
            end
         end

         if (pulse_out === 1'b1 && prev !== 1'b1) start = cyc;
         if (pulse_out !== 1'b1 && prev === 1'b1) begin
            checks++;
            if (level_q.size() == 0) begin
               errors++;
               $display("FAIL level: unexpected level start %0d width %0d", start, cyc - start);
            end else begin
               l = level_q.pop_front();
               if (start != l.start) begin
                  errors++;
                  $display("FAIL level start: got %0d want %0d", start, l.start);
               end
               checks++;
               if (cyc - start != l.width) begin
                  errors++;
                  $display("FAIL level width (start %0d): got %0d want %0d", start, cyc - start,
                           l.width);
               end
            end
         end
         prev = (pulse_out === 1'b1);

         if (overflow === 1'b1) begin
            checks++;
            if (ovf_q.size() == 0) begin
               errors++;
               $display("FAIL overflow: unexpected at cyc %0d", cyc);
            end else if (ovf_q[0] != cyc) begin
               errors++;
               $display("FAIL overflow: got cyc %0d want cyc %0d", cyc, ovf_q.pop_front());
            end else begin
               void'(ovf_q.pop_front());
            end
         end
         while (ovf_q.size() > 0 && ovf_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL overflow: missing at cyc %0d got 0 want 1", ovf_q.pop_front());
         end
      end
   end

   // Stimulus
   initial begin
      // Reset held with strobe high: everything stays 0.
      for (int c = 1; c <= 3; c++) begin
         for (int s = 0; s < 4; s++) exp_probe(c, s, 0);
      end
      set_at(1, 1'b1, 1'b0);
      set_at(4, 1'b0, 1'b1);

      // First strobe after reset.
      exp_level(6, 4);
      exp_probe(11, SigBusy, 1);
      exp_probe(12, SigBusy, 0);
      pulse(6);

      // Single strobe.
      exp_level(20, 4);
      exp_probe(21, SigPend, 0);
      exp_probe(24, SigPulse, 0);
      exp_probe(25, SigBusy, 1);
      exp_probe(26, SigBusy, 0);
      pulse(20);

      // Strobes at 30, 32, 33.
      exp_level(30, 4);
`ifdef PULSE_QUEUE_EN
      exp_level(36, 4);
      exp_level(42, 4);
      exp_probe(32, SigPend, 1);
      exp_probe(33, SigPend, 2);
      exp_probe(35, SigPend, 2);
      exp_probe(36, SigPend, 1);
      exp_probe(42, SigPend, 0);
      exp_probe(47, SigBusy, 1);
      exp_probe(48, SigBusy, 0);
`else
      exp_ovf(32);
      exp_ovf(33);
      exp_probe(33, SigPend, 0);
      exp_probe(35, SigBusy, 1);
      exp_probe(36, SigBusy, 0);
`endif
      set_at(30, 1'b1, 1'b1);
      set_at(31, 1'b0, 1'b1);
      set_at(32, 1'b1, 1'b1);
      set_at(34, 1'b0, 1'b1);

      // Five consecutive strobes: saturation and drop.
      exp_level(50, 4);
`ifdef PULSE_QUEUE_EN
      exp_level(56, 4);
      exp_level(62, 4);
      exp_level(68, 4);
      exp_probe(53, SigPend, 3);
      exp_probe(54, SigPend, 3);
      exp_probe(55, SigOvf, 0);
      exp_probe(56, SigPend, 2);
      exp_probe(68, SigPend, 0);
      exp_probe(73, SigBusy, 1);
      exp_probe(74, SigBusy, 0);
      exp_ovf(54);
`else
      exp_ovf(51);
      exp_ovf(52);
      exp_ovf(53);
      exp_ovf(54);
      exp_probe(54, SigPend, 0);
      exp_probe(56, SigBusy, 0);
`endif
      set_at(50, 1'b1, 1'b1);
      set_at(55, 1'b0, 1'b1);

      // Strobe on the final GAP cycle, then a queued strobe, then reset mid-HIGH.
      exp_level(80, 4);
      exp_level(86, 2);
      exp_probe(85, SigBusy, 1);
      exp_probe(86, SigPend, 0);
      exp_probe(86, SigOvf, 0);
`ifdef PULSE_QUEUE_EN
      exp_probe(87, SigPend, 1);
`else
      exp_probe(87, SigPend, 0);
      exp_ovf(87);
`endif
      exp_probe(88, SigPulse, 0);
      exp_probe(88, SigBusy, 0);
      exp_probe(88, SigPend, 0);
      exp_probe(90, SigBusy, 0);
      exp_probe(92, SigPulse, 0);
      pulse(80);
      set_at(86, 1'b1, 1'b1);
      set_at(88, 1'b0, 1'b0);
      set_at(89, 1'b0, 1'b1);

      set_at(101, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      checks++;
      if (probe_q.size() != 0) begin
         errors++;
         $display("FAIL probes left: got %0d want 0", probe_q.size());
      end
      checks++;
      if (level_q.size() != 0) begin
         errors++;
         $display("FAIL levels left: got %0d want 0", level_q.size());
      end
      checks++;
      if (ovf_q.size() != 0) begin
         errors++;
         $display("FAIL overflows left: got %0d want 0", ovf_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_level_gen.md
# pulse_level_gen

Pulse-to-level generator: the inverse of the level-to-pulse edge detector used after the switch sampling chain. It accepts single-cycle strobes and emits each one as a clean, fixed-width high level followed by a fixed low gap, so downstream sampling/edge-detect logic sees exactly one rising edge per strobe. Strobes that arrive while a level is in progress are queued in a saturating pending counter. It sits between control logic that issues strobes and any input expecting a held, debounce-compatible level.

## Interface

Parameters:
- HIGH_CYCLES, 16: clock cycles `pulse_out` is held high per strobe; must be ≥1.
- GAP_CYCLES, 16: clock cycles `pulse_out` is held low after each high level; must be ≥1.
- CNT_W, 8: width of the internal phase counter; must satisfy 2^CNT_W ≥ max(HIGH_CYCLES, GAP_CYCLES).
- PEND_W, 4: width of the pending counter. The maximum pending count is 2^PEND_W−1.

Ports:
- clk, input, 1: system clock. All logic is rising-edge.
- rst, input, 1: reset. One clock; reset is synchronous and active-low.
- strobe, input, 1: request for one output level. Sampled every rising edge; each high cycle is one request.
- pulse_out, output, 1: generated level. Registered.
- busy, output, 1: high whenever the FSM is not in IDLE. Registered.
- pending, output, PEND_W: number of queued requests not yet started.
- overflow, output, 1: one-cycle registered pulse whenever a request is dropped.

## Operation

- Reset (rst=0 at a rising edge):
  - State becomes IDLE.
  - `pulse_out`=0, `busy`=0, `pending`=0, `overflow`=0, phase counter=0.
  - Reset takes precedence over all other activity, including mid-HIGH or mid-GAP. Any in-progress level ends and queued requests are discarded.
- States:
  - IDLE
    - On `strobe`: go to HIGH and load the counter with HIGH_CYCLES−1.
    - Otherwise: stay in IDLE.
  - HIGH
    - `pulse_out`=1.
    - If counter≠0: decrement the counter.
    - If counter=0: go to GAP and load the counter with GAP_CYCLES−1.
  - GAP
    - `pulse_out`=0.
    - If counter≠0: decrement the counter.
    - If counter=0 and (`pending`>0 or `strobe`): go to HIGH and load the counter with HIGH_CYCLES−1.
    - If counter=0 and neither: go to IDLE.
- Request accounting in HIGH and GAP, per cycle:
  - A `strobe` that does not start a level increments `pending`.
  - A transition GAP→HIGH with `strobe`=0 decrements `pending`.
  - A GAP→HIGH transition with `strobe`=1 and `pending`=0 consumes the strobe directly; `pending` stays 0.
  - A GAP→HIGH transition with `strobe`=1 and `pending`>0 leaves `pending` unchanged (net +1−1).
- Saturation:
  - A strobe arriving when `pending`=2^PEND_W−1 and no dequeue occurs that cycle is dropped.
  - `pending` holds its value and `overflow` pulses high for the next cycle.
- Arithmetic:
  - `pending` never wraps.
  - The phase counter never underflows; the load happens at 0.

## Timing

- Latency: a `strobe` sampled in IDLE at edge k gives `pulse_out`=1 for the cycles following edges k..k+HIGH_CYCLES−1, i.e. first high cycle starts one cycle after the strobe.
- Period: back-to-back queued levels repeat every HIGH_CYCLES+GAP_CYCLES cycles, with no extra idle cycle between them.
- `busy` follows the same timing as the state register: it rises with `pulse_out` and falls the cycle after the final GAP cycle when nothing is pending.
- `overflow` is high exactly one cycle per dropped strobe. Consecutive drops give consecutive high cycles.

## Configuration

- PULSE_QUEUE_EN defined: queuing behaves as specified above.
- PULSE_QUEUE_EN undefined:
  - `pending` is tied to 0 and no counter is built.
  - Any `strobe` in HIGH or GAP is dropped and pulses `overflow`.
  - The exception is a strobe on the final GAP cycle (counter=0), which still starts the next HIGH directly.

## Test plan

All scenarios use HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2, PULSE_QUEUE_EN defined unless noted.

- Reset value: hold rst=0 for 3 cycles with `strobe`=1 -> all outputs 0. Release -> first strobe gives `pulse_out` high for 4 cycles, starting one cycle later.
- Single strobe: strobe at cycle 10 -> `pulse_out`=1 for cycles 11–14, 0 for cycles 15–16. `busy`=0 from cycle 17.
- Queuing: strobes at cycles 10, 12, 13 -> `pending` goes 1 then 2. Levels start at cycles 11, 17, 23. `pending` returns to 0 at cycle 23.
- Overflow: 5 strobes during one HIGH -> `pending` saturates at 3 and `overflow` pulses once, for the 4th queued strobe. The bench must confirm that 4 levels are produced in total.
- Final-gap strobe plus reset: strobe exactly on the last GAP cycle with `pending`=0 -> the next HIGH starts immediately and `pending` stays 0. Then assert rst=0 mid-HIGH -> `pulse_out` and `busy` are 0 at the next edge.
- PULSE_QUEUE_EN undefined: strobe at cycles 10 and 12 -> one level only. `overflow`=1 at cycle 13 and `pending` stays 0.
